// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - control, byte stream and instruction memory write signals of imem_loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [31:0]       im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              csum_err;

    modport master (
        output start, num_words, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, csum_err
    );

    modport slave (
        input  start, num_words, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, csum_err
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial instruction memory loader, trailing XOR checksum under IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imem_loader_if.slave  bus
);

    localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic              hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              err_q, err_d;
`endif

    logic [ADDR_W:0]   clamped;
    logic              last_word;

    assign clamped   = (bus.num_words > CAP) ? CAP : bus.num_words;
    assign last_word = ({1'b0, idx_q} == (count_q - CNT_ONE));

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    // next-state and datapath updates; a zero-length load never holds the CPU
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hold_d  = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d = '0;
                    cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = '0;
                    err_d = 1'b0;
`endif
                    if (clamped == '0) begin
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        count_d = clamped;
                        hold_d  = 1'b1;
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (bus.byte_valid) begin
                    shift_d = {shift_q[23:0], bus.byte_data};
                    cnt_d   = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ bus.byte_data;
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (bus.byte_valid) begin
                    err_d   = (bus.byte_data != xor_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
    assign bus.csum_err   = err_q;
`else
    assign bus.byte_ready = (state_q == S_RECV);
    assign bus.csum_err   = 1'b0;
`endif
    assign bus.im_we    = (state_q == S_WRITE);
    assign bus.im_addr  = (state_q == S_WRITE) ? 32'({idx_q, 2'b00}) : 32'h0;
    assign bus.im_wdata = (state_q == S_WRITE) ? shift_q : 32'h0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.cpu_hold = (state_q != S_IDLE) && hold_q;
    assign bus.done     = (state_q == S_DONE);

endmodule
